// File: rtl/residue_req_scheduler.sv
// Round-robin arbiter feeding one shared mod-7 residue unit.
// Streams a 48-bit operand as 6-bit chunks and returns the residue.
module residue_req_scheduler #(
  parameter int TIMEOUT = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  Req,
  input  logic [47:0] Data0,
  input  logic [47:0] Data1,
  output logic [1:0]  Gnt,
  output logic [5:0]  Res_D_in,
  output logic        Res_Clear,
  input  logic [2:0]  Res_D_out,
  input  logic        Res_Ready,
  output logic        Out_Valid,
  input  logic        Out_Accept,
  output logic [2:0]  Out_Residue,
  output logic        Out_Id,
  output logic        Out_Error,
  output logic        Busy
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    WAIT,
    DONE
  } state_t;

  state_t      state, nxt_state;
  logic        ptr, nxt_ptr;
  logic [2:0]  k, nxt_k;
  logic [7:0]  tcnt, nxt_t;
  logic [47:0] op, nxt_op;
  logic        id_q, nxt_id;
  logic        sel;

  logic [1:0]  nxt_gnt;
  logic [5:0]  nxt_din;
  logic        nxt_clr;
  logic        nxt_valid;
  logic [2:0]  nxt_res;
  logic        nxt_oid;
  logic        nxt_err;

  // Next state, bookkeeping and registered-output values.
  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_k     = k;
    nxt_t     = tcnt;
    nxt_op    = op;
    nxt_id    = id_q;
    nxt_gnt   = 2'b00;
    nxt_din   = 6'd0;
    nxt_clr   = 1'b0;
    nxt_valid = Out_Valid;
    nxt_res   = Out_Residue;
    nxt_oid   = Out_Id;
    nxt_err   = Out_Error;
    sel       = 1'b0;
    unique case (state)
      IDLE: begin
        if (Req != 2'b00) begin
          unique case (1'b1)
            (Req == 2'b11): sel = ptr;
            (Req == 2'b10): sel = 1'b1;
            default:        sel = 1'b0;
          endcase
          nxt_gnt   = sel ? 2'b10 : 2'b01;
          nxt_op    = sel ? Data1 : Data0;
          nxt_id    = sel;
          nxt_clr   = 1'b1;
          nxt_state = CLEAR;
        end
      end
      CLEAR: begin
        nxt_k     = 3'd0;
        nxt_din   = op[47:42];
        nxt_op    = op << 6;
        nxt_state = FEED;
      end
      FEED: begin
        if (k == 3'd7) begin
          nxt_t     = 8'd0;
          nxt_state = WAIT;
        end else begin
          nxt_k   = k + 3'd1;
          nxt_din = op[47:42];
          nxt_op  = op << 6;
        end
      end
      WAIT: begin
        if (Res_Ready) begin
          nxt_res   = Res_D_out;
          nxt_err   = 1'b0;
          nxt_oid   = id_q;
          nxt_valid = 1'b1;
          nxt_state = DONE;
        end else if (tcnt == TO) begin
          nxt_res   = 3'd0;
          nxt_err   = 1'b1;
          nxt_oid   = id_q;
          nxt_valid = 1'b1;
          nxt_state = DONE;
        end else begin
          nxt_t = tcnt + 8'd1;
        end
      end
      DONE: begin
        if (Out_Accept) begin
          nxt_valid = 1'b0;
          nxt_ptr   = ~id_q;
          nxt_t     = 8'd0;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      k           <= 3'd0;
      tcnt        <= 8'd0;
      op          <= 48'd0;
      id_q        <= 1'b0;
      Gnt         <= 2'b00;
      Res_D_in    <= 6'd0;
      Res_Clear   <= 1'b0;
      Out_Valid   <= 1'b0;
      Out_Residue <= 3'd0;
      Out_Id      <= 1'b0;
      Out_Error   <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      state       <= nxt_state;
      ptr         <= nxt_ptr;
      k           <= nxt_k;
      tcnt        <= nxt_t;
      op          <= nxt_op;
      id_q        <= nxt_id;
      Gnt         <= nxt_gnt;
      Res_D_in    <= nxt_din;
      Res_Clear   <= nxt_clr;
      Out_Valid   <= nxt_valid;
      Out_Residue <= nxt_res;
      Out_Id      <= nxt_oid;
      Out_Error   <= nxt_err;
      Busy        <= (nxt_state != IDLE);
    end
  end

endmodule

// File: tb/tb_residue_req_scheduler.sv
// Directed bench for residue_req_scheduler.
// Includes a simple mod-7 unit model driving Ready one cycle after chunk 7.
module tb_residue_req_scheduler;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  Req = 2'b00;
  logic [47:0] Data0 = 48'd0;
  logic [47:0] Data1 = 48'd0;
  logic [1:0]  Gnt;
  logic [5:0]  Res_D_in;
  logic        Res_Clear;
  logic [2:0]  Res_D_out;
  logic        Res_Ready;
  logic        Out_Valid;
  logic        Out_Accept = 1'b0;
  logic [2:0]  Out_Residue;
  logic        Out_Id;
  logic        Out_Error;
  logic        Busy;

  residue_req_scheduler #(.TIMEOUT(15)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req),
    .Data0(Data0), .Data1(Data1), .Gnt(Gnt),
    .Res_D_in(Res_D_in), .Res_Clear(Res_Clear),
    .Res_D_out(Res_D_out), .Res_Ready(Res_Ready),
    .Out_Valid(Out_Valid), .Out_Accept(Out_Accept),
    .Out_Residue(Out_Residue), .Out_Id(Out_Id),
    .Out_Error(Out_Error), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // mod-7 unit model
  logic       ready_mode = 1'b1;
  logic       model_rdy = 1'b0;
  logic [2:0] acc = 3'd0;
  int         mn = 8;
  logic       force_rdy = 1'b0;
  logic [2:0] force_val = 3'd0;

  always @(posedge Clock) begin
    if (Res_Clear) begin
      acc <= 3'd0;
      mn <= 0;
      model_rdy <= 1'b0;
    end else if (mn < 8) begin
      acc <= 3'((int'(acc) + int'(Res_D_in)) % 7);
      mn <= mn + 1;
      if (mn == 7) model_rdy <= ready_mode;
    end
  end

  assign Res_Ready = model_rdy | force_rdy;
  assign Res_D_out = force_rdy ? force_val : acc;

  int total = 0;
  int bad = 0;
  logic [5:0] chunks [8];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_grant(input logic [1:0] req, input logic [47:0] d0,
                          input logic [47:0] d1, input logic [1:0] eg);
    int n;
    n = 0;
    Req = req;
    Data0 = d0;
    Data1 = d1;
    @(negedge Clock);
    while (Gnt == 2'b00 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check("gnt", 64'(Gnt), 64'(eg));
    check("clear", 64'(Res_Clear), 64'd1);
    check("clear_din", 64'(Res_D_in), 64'd0);
    check("busy", 64'(Busy), 64'd1);
    Req = 2'b00;
  endtask

  task automatic feed_chunks(input logic [47:0] op);
    logic [47:0] sh;
    sh = op;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      chunks[i] = Res_D_in;
      check("chunk", 64'(Res_D_in), 64'(sh[47:42]));
      if (i == 0) check("clear_drop", 64'(Res_Clear), 64'd0);
      sh = sh << 6;
    end
  endtask

  task automatic do_accept();
    Out_Accept = 1'b1;
    @(negedge Clock);
    check("valid_drop", 64'(Out_Valid), 64'd0);
    check("idle_busy", 64'(Busy), 64'd0);
    Out_Accept = 1'b0;
  endtask

  task automatic do_rest(input logic [47:0] op, input int ew,
                         input logic [2:0] er, input logic eid,
                         input logic eerr, input logic acc_now);
    int n;
    feed_chunks(op);
    n = 0;
    while (!Out_Valid && n < 40) begin
      @(negedge Clock);
      n++;
    end
    check("latency", 64'(n), 64'(ew));
    check("residue", 64'(Out_Residue), 64'(er));
    check("id", 64'(Out_Id), 64'(eid));
    check("error", 64'(Out_Error), 64'(eerr));
    if (acc_now) do_accept();
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [47:0] d0;
    logic [47:0] d1;
    logic [1:0]  gnt;
    logic        id;
    logic [2:0]  res;
  } vec_t;

  vec_t vt [8];
  int   tp [8];
  logic [47:0] tmp;

  initial begin
    vt[0] = '{2'b11, 48'h0, 48'hFFFFFFFFFFFF, 2'b01, 1'b0, 3'd0};
    vt[1] = '{2'b11, 48'h0, 48'hFFFFFFFFFFFF, 2'b10, 1'b1, 3'd0};
    vt[2] = '{2'b11, 48'h0, 48'hFFFFFFFFFFFF, 2'b01, 1'b0, 3'd0};
    vt[3] = '{2'b11, 48'h0, 48'hFFFFFFFFFFFF, 2'b10, 1'b1, 3'd0};
    vt[4] = '{2'b01, 48'hE88FCA302C89, 48'h0, 2'b01, 1'b0, 3'd2};
    vt[5] = '{2'b10, 48'h0, 48'h123456789ABC, 2'b10, 1'b1, 3'd2};
    vt[6] = '{2'b11, 48'h800000000000, 48'h5, 2'b01, 1'b0, 3'd4};
    vt[7] = '{2'b11, 48'h5, 48'h6, 2'b10, 1'b1, 3'd6};
    tp = '{58, 8, 63, 10, 12, 2, 50, 9};

    #1;
    check("rst_outs", 64'({Gnt, Res_D_in, Res_Clear, Out_Valid,
                           Out_Residue, Out_Id, Out_Error}), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    for (int i = 0; i < 8; i++) begin
      do_grant(vt[i].req, vt[i].d0, vt[i].d1, vt[i].gnt);
      do_rest(vt[i].gnt[1] ? vt[i].d1 : vt[i].d0, 2,
              vt[i].res, vt[i].id, 1'b0, 1'b1);
      if (i == 4)
        for (int j = 0; j < 8; j++)
          check("tp_chunk", 64'(chunks[j]), 64'(tp[j]));
    end

    // timeout: no Ready, error result 16 cycles after WAIT entry
    ready_mode = 1'b0;
    do_grant(2'b01, 48'h800000000000, 48'h0, 2'b01);
    do_rest(48'h800000000000, 17, 3'd0, 1'b0, 1'b1, 1'b1);
    ready_mode = 1'b1;

    // backpressure, also checks pointer moved after the error
    do_grant(2'b11, 48'h5, 48'h800000000000, 2'b10);
    do_rest(48'h800000000000, 2, 3'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      Req = 2'(i);
      @(negedge Clock);
      check("bp_valid", 64'(Out_Valid), 64'd1);
      check("bp_res", 64'(Out_Residue), 64'd4);
      check("bp_id", 64'(Out_Id), 64'd1);
      check("bp_gnt", 64'(Gnt), 64'd0);
    end
    Req = 2'b01;
    Out_Accept = 1'b1;
    @(negedge Clock);
    Out_Accept = 1'b0;
    check("bp_idle_valid", 64'(Out_Valid), 64'd0);
    check("bp_idle_gnt", 64'(Gnt), 64'd0);
    @(negedge Clock);
    check("bp_next_gnt", 64'(Gnt), 64'd1);
    Req = 2'b00;
    do_rest(48'h5, 2, 3'd5, 1'b0, 1'b0, 1'b1);

    // reset during chunk 3
    tmp = 48'h123456789ABC;
    do_grant(2'b10, 48'h0, tmp, 2'b10);
    repeat (4) @(negedge Clock);
    check("pre_rst_chunk3", 64'(Res_D_in), 64'(tmp[29:24]));
    #2 Reset = 1'b0;
    #1;
    check("async_rst_outs", 64'({Gnt, Res_D_in, Res_Clear, Out_Valid,
                                 Out_Residue, Out_Id, Out_Error}), 64'd0);
    check("async_rst_busy", 64'(Busy), 64'd0);
    @(negedge Clock);
    Reset = 1'b1;
    do_grant(2'b11, 48'hE88FCA302C89, tmp, 2'b01);
    do_rest(48'hE88FCA302C89, 2, 3'd2, 1'b0, 1'b0, 1'b1);

    // Ready arrives on the timeout cycle
    ready_mode = 1'b0;
    do_grant(2'b01, 48'h6, 48'h0, 2'b01);
    feed_chunks(48'h6);
    repeat (15) @(negedge Clock);
    check("tie_not_yet", 64'(Out_Valid), 64'd0);
    @(negedge Clock);
    force_val = 3'd5;
    force_rdy = 1'b1;
    @(negedge Clock);
    force_rdy = 1'b0;
    check("tie_valid", 64'(Out_Valid), 64'd1);
    check("tie_res", 64'(Out_Residue), 64'd5);
    check("tie_err", 64'(Out_Error), 64'd0);
    do_accept();
    ready_mode = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
